// File: rtl/reg_bank_writer_if.sv
// Write-request bus between the datapath and the register-bank writer.
//
// Handshake: the requester raises wr_valid with wr_addr/wr_data and holds all
// three stable until a rising edge where wr_valid & wr_ready are both high;
// that edge is the transfer. wr_ready never depends on wr_valid.
interface reg_bank_writer_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  wr_valid;
    logic                  wr_ready;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/reg_bank_writer.sv
// Register-bank write side: an in-order write queue feeding a 32-entry
// register array. One queued write retires per cycle while commit_en is high.
// reg_q shows committed data only; pending_mask flags registers that still
// have writes in flight so control can stall reads of them.
module reg_bank_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic                         clk,
    input  logic                         clr,
    reg_bank_writer_if.slave             wr_bus,
    input  logic                         commit_en,
    output logic [32*DATA_WIDTH-1:0]     reg_q,
    output logic [31:0]                  pending_mask,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         busy
);

    localparam int NUM_REGS = 32;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    // Queue storage and bookkeeping
    logic [4:0]            r_q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Architectural register array
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Handshake / retire decode
    logic                  w_full;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_commit;
    logic [4:0]            w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_writable;

    // Per-slot occupancy
    logic [PTR_W-1:0]      w_offset [DEPTH];
    logic [DEPTH-1:0]      w_slot_valid;
    logic [31:0]           w_pending;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    // No pass-through when full: a same-cycle commit does not open a slot
    // until the following cycle, which keeps ready off the commit path.
    assign w_ready  = ~clr & ~w_full;
    assign w_accept = wr_bus.wr_valid & w_ready;
    assign w_commit = commit_en & (r_count != '0) & ~clr;

    assign w_head_addr = r_q_addr[r_rd_ptr];
    assign w_head_data = r_q_data[r_rd_ptr];
    // A hardwired R0 still consumes a slot and a commit cycle; only the
    // array update is suppressed.
    assign w_head_writable = ~(R0_HARDWIRED && (w_head_addr == 5'd0));

    assign wr_bus.wr_ready = w_ready;

    // Capture accepted requests at the write pointer; contents need no reset
    // because the occupancy logic ignores slots outside the live window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_addr[r_wr_ptr] <= wr_bus.wr_addr;
            r_q_data[r_wr_ptr] <= wr_bus.wr_data;
        end
    end

    // Pointers and occupancy count; DEPTH is a power of two so the pointers
    // wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_commit) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_accept, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Retire the queue head into the register array.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_head_writable) begin
            r_regs[w_head_addr] <= w_head_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign w_offset[g]     = PTR_W'(g) - r_rd_ptr;
        assign w_slot_valid[g] = ({1'b0, w_offset[g]} < r_count);
    end

    // OR the one-hot destination of every live slot; depends on queue state
    // only, never on this cycle's request or commit_en.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                w_pending[r_q_addr[i]] = 1'b1;
            end
        end
        if (R0_HARDWIRED) begin
            w_pending[0] = 1'b0;
        end
    end

    // Flatten the register array for the bus-read multiplexer.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign pending_mask = w_pending;
    assign count        = r_count;
    assign busy         = (r_count != '0);

endmodule
